multiplex_unit: RTL and testbench
=================================

Name: multiplex_unit

Overview:
- Parameterised 2:1 selector. Output equals input b when sel=1 and input a when sel=0, applied per bit: y = (a AND NOT sel) OR (b AND sel).
- Provides a combinational output and a registered, enable-qualified output.
- With the optional feature compiled in, three independent implementations (gate, dataflow, behavioural) run in parallel and are cross-checked.
- Used as a datapath select leaf and as a self-checking reference cell.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data selected when sel=0.
- b  input  WIDTH  data selected when sel=1.
- sel  input  1  select.
- en  input  1  capture enable for y_q.
- clr  input  1  synchronous clear of mismatch status.
- y  output  WIDTH  combinational select result, zero cycles latency.
- y_q  output  WIDTH  registered select result.
- vld_q  output  1  high the cycle after a capture (en=1), otherwise low.
- mismatch  output  1  sticky flag: implementations disagreed.
- mismatch_cnt  output  CNT_W  saturating count of disagreeing cycles.

Behaviour:
- Truth table per bit, as (a,b,sel) -> y:
  - (0,0,0)->0, (0,0,1)->0, (0,1,0)->0, (0,1,1)->1
  - (1,0,0)->1, (1,0,1)->0, (1,1,0)->1, (1,1,1)->1
- y is purely combinational from a, b, sel. It is independent of clk, rst_n and en.
- rst_n low, asynchronous: y_q=0, vld_q=0, mismatch=0, mismatch_cnt=0. Release takes effect at the next rising edge. y is unaffected by reset.
- Rising edge with en=1: y_q <= y, vld_q <= 1.
- Rising edge with en=0: y_q holds its value, vld_q <= 0.
- Latency: y is 0 cycles; y_q and vld_q are 1 cycle.
- Cross-check, per rising edge when not in reset:
  - disagree = (y_gate != y_data) OR (y_gate != y_behav), using case inequality so X/Z mismatches are caught in simulation.
  - If disagree: mismatch <= 1 and mismatch_cnt increments, saturating at all-ones (no wrap).
- clr=1 at an edge: mismatch <= 0 and mismatch_cnt <= 0. clr wins over a simultaneous disagreement.
- Reset asserted mid-operation clears all state immediately, including a saturated counter.
- The public output y is driven from the behavioural implementation.

Optional Feature:
- MULTIPLEX_UNIT_CROSSCHECK_EN defined:
  - Instantiates the gate-level implementation (AND/OR/NOT primitives per bit), the dataflow implementation (continuous assign of the boolean equation) and the behavioural implementation (procedural if/case on sel).
  - Enables the mismatch logic.
- Undefined:
  - Only the behavioural implementation exists.
  - mismatch is tied 0 and mismatch_cnt is tied 0; clr is ignored.
  - Port list is unchanged.

Decomposition:
- Package multiplex_pkg holds:
  - MUX_WIDTH_DEFAULT=1
  - MUX_CNT_W_DEFAULT=8
  - enum mux_impl_e {IMPL_GATE, IMPL_DATA, IMPL_BEHAV} for debug/reporting
  - function mux_ref(a,b,sel) returning the golden per-bit result
- One sub-module: multiplex_bitslice_gate, a single-bit gate-level cell built from primitives only, replicated WIDTH times by generate.
- Dataflow and behavioural implementations stay inline in multiplex_unit.

Test Plan:
- WIDTH=1 exhaustive sweep of {a,b,sel}=0..7, 10 ns settle each -> y sequence 0,0,0,1,1,0,1,1. With the feature compiled in, all three internal implementations match and mismatch stays 0.
- WIDTH=8, a=8'hA5, b=8'h3C: sel=0 gives y=8'hA5, sel=1 gives y=8'h3C. With en=1 for one edge, y_q=8'h3C and vld_q=1 for exactly one cycle. With en=0, y_q holds 8'h3C and vld_q=0.
- Reset: drive y_q=8'hFF, then pulse rst_n low between edges -> y_q=0 and vld_q=0 immediately, with no clock required. y still follows its inputs.
- Force the internal dataflow output to differ (feature on) for 3 edges -> mismatch=1 and mismatch_cnt=3. Then clr=1 on the same edge as a further disagreement -> mismatch=0 and mismatch_cnt=0.
- Saturation with CNT_W=2: 5 consecutive disagreeing edges -> mismatch_cnt=3, no wrap to 0.
- Feature undefined: same forced disagreement -> mismatch=0 and mismatch_cnt=0. Truth table still passes.

Source files
------------

// File: rtl/multiplex_pkg.sv
// Shared defaults, implementation tags and golden per-bit reference for multiplex_unit.
package multiplex_pkg;

  localparam int MUX_WIDTH_DEFAULT = 1;
  localparam int MUX_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IMPL_GATE  = 2'd0,
    IMPL_DATA  = 2'd1,
    IMPL_BEHAV = 2'd2
  } mux_impl_e;

  function automatic logic mux_ref(input logic a, input logic b, input logic sel);
    return (a & ~sel) | (b & sel);
  endfunction

endpackage

// File: rtl/multiplex_bitslice_gate.sv
// Single-bit 2:1 select built only from gate primitives; 0 cycles, no flow control.
module multiplex_bitslice_gate (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  wire sel_n;
  wire a_term;
  wire b_term;
  wire y_w;

  not u_not (sel_n, sel);
  and u_and_a (a_term, a, sel_n);
  and u_and_b (b_term, b, sel);
  or  u_or (y_w, a_term, b_term);

  assign y = y_w;

endmodule

// File: rtl/multiplex_unit.sv
// 2:1 selector: y combinational (0 cycles), y_q/vld_q registered (1 cycle), no backpressure.
// MULTIPLEX_UNIT_CROSSCHECK_EN adds gate/dataflow copies and a sticky, saturating mismatch monitor.
module multiplex_unit
  import multiplex_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT,
  parameter int CNT_W = MUX_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             vld_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic [WIDTH-1:0] y_behav;
  logic [WIDTH-1:0] y_d;
  logic             vld_d;

  always_comb begin
    y_behav = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (sel)
        1'b1:    y_behav[i] = b[i];
        default: y_behav[i] = a[i];
      endcase
    end
  end

  assign y = y_behav;

  always_comb begin
    y_d   = en ? y_behav : y_q;
    vld_d = en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

`ifdef MULTIPLEX_UNIT_CROSSCHECK_EN
  logic [WIDTH-1:0] y_gate;
  logic [WIDTH-1:0] y_data;
  logic             disagree;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_gate
    multiplex_bitslice_gate u_slice (
      .a   (a[g]),
      .b   (b[g]),
      .sel (sel),
      .y   (y_gate[g])
    );
  end

  assign y_data = (a & ~{WIDTH{sel}}) | (b & {WIDTH{sel}});

  // Case inequality so an X/Z on any copy counts as a disagreement in simulation.
  assign disagree = (y_gate !== y_data) || (y_gate !== y_behav);

  always_comb begin
    mismatch_d = mismatch_q;
    cnt_d      = cnt_q;
    if (clr) begin
      mismatch_d = 1'b0;
      cnt_d      = '0;
    end else if (disagree) begin
      mismatch_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = clr;
  assign mismatch     = 1'b0;
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_multiplex_unit.sv
// Directed bench for multiplex_unit: an 8-bit instance and a 1-bit instance with a 2-bit counter.
module tb_multiplex_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a8, b8;
  logic       sel8, en8, clr8;
  logic [7:0] y8, y_q8;
  logic       vld8, mm8;
  logic [7:0] cnt8;
  logic       a1, b1, sel1, en1, clr1;
  logic       y1, y_q1, vld1, mm1;
  logic [1:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  multiplex_unit #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .en(en8), .clr(clr8),
    .y(y8), .y_q(y_q8), .vld_q(vld8), .mismatch(mm8), .mismatch_cnt(cnt8)
  );

  multiplex_unit #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .en(en1), .clr(clr1),
    .y(y1), .y_q(y_q1), .vld_q(vld1), .mismatch(mm1), .mismatch_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tt;
    tt = 8'b1101_1000;  // y for {a,b,sel} = 7..0
    a8 = '0; b8 = '0; sel8 = 0; en8 = 0; clr8 = 0;
    a1 = 0;  b1 = 0;  sel1 = 0; en1 = 0; clr1 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y_q", y_q8, 8'h00);
    chk("rst_vld", vld8, 0);
    chk("rst_mm", mm8, 0);
    chk("rst_cnt", cnt8, 8'h00);
    #9 rst_n = 1'b1;

    // Exhaustive truth table on the 1-bit instance
    @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      {a1, b1, sel1} = v[2:0];
      #10;
      chk($sformatf("tt_%0d", v), y1, tt[v]);
    end
    chk("tt_mm", mm1, 0);
    chk("tt_cnt", cnt1, 0);

    // 8-bit select and capture
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 0;
    #1 chk("sel0_y", y8, 8'hA5);
    sel8 = 1;
    #1 chk("sel1_y", y8, 8'h3C);
    chk("pre_vld", vld8, 0);
    en8 = 1;
    @(negedge clk);
    chk("cap_y_q", y_q8, 8'h3C);
    chk("cap_vld", vld8, 1);
    en8 = 0; b8 = 8'h00;
    @(negedge clk);
    chk("hold_y_q", y_q8, 8'h3C);
    chk("hold_vld", vld8, 0);
    chk("hold_y", y8, 8'h00);

    // Asynchronous reset between edges
    b8 = 8'hFF; en8 = 1;
    @(negedge clk);
    en8 = 0;
    chk("ff_y_q", y_q8, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y_q", y_q8, 8'h00);
    chk("arst_vld", vld8, 0);
    sel8 = 0;
    #1 chk("arst_y", y8, 8'hA5);
    rst_n = 1'b1;

`ifdef MULTIPLEX_UNIT_CROSSCHECK_EN
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; sel8 = 0;
    force dut8.y_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("xc_mm", mm8, 1);
    chk("xc_cnt", cnt8, 8'd3);
    clr8 = 1;
    @(negedge clk);
    chk("clr_mm", mm8, 0);
    chk("clr_cnt", cnt8, 8'd0);
    clr8 = 0;
    release dut8.y_data;
    @(negedge clk);
    chk("post_mm", mm8, 0);
    chk("post_cnt", cnt8, 8'd0);

    a1 = 0; b1 = 0; sel1 = 0;
    force dut1.y_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat_cnt", cnt1, 2'd3);
    chk("sat_mm", mm1, 1);
    release dut1.y_data;
    #2 rst_n = 1'b0;
    #1;
    chk("sat_rst_cnt", cnt1, 2'd0);
    chk("sat_rst_mm", mm1, 0);
    rst_n = 1'b1;
`else
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; sel8 = 0;
    repeat (3) @(negedge clk);
    chk("off_mm", mm8, 0);
    chk("off_cnt", cnt8, 8'd0);
    clr8 = 1;
    @(negedge clk);
    clr8 = 0;
    repeat (5) @(negedge clk);
    chk("off_mm1", mm1, 0);
    chk("off_cnt1", cnt1, 2'd0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
